// File: rtl/decode_exec_stage.sv
// Decode-to-execute pipeline register with N-way operand forwarding,
// load-use bubble insertion, stall-hold with operand refresh and deferred flush.
module decode_exec_stage #(
   parameter int WORD_W = 32,
   parameter int REG_W  = 5,
   parameter int NFWD   = 2,
   parameter int PAY_W  = 48
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    dec_valid,
   input  logic [WORD_W-1:0]       dec_alu_in1,
   input  logic [WORD_W-1:0]       dec_alu_in2,
   input  logic                    dec_fwd1,
   input  logic                    dec_fwd2,
   input  logic [REG_W-1:0]        dec_rs,
   input  logic [REG_W-1:0]        dec_rt,
   input  logic [WORD_W-1:0]       dec_store,
   input  logic [REG_W-1:0]        dec_wsel,
   input  logic                    dec_memread,
   input  logic [PAY_W-1:0]        dec_payload,
   input  logic                    stall,
   input  logic                    flush,
   input  logic [NFWD-1:0]         fwd_valid,
   input  logic [NFWD*REG_W-1:0]   fwd_wsel,
   input  logic [NFWD*WORD_W-1:0]  fwd_wdat,
   output logic                    hazard,
   output logic                    ex_valid,
   output logic [WORD_W-1:0]       ex_alu_in1,
   output logic [WORD_W-1:0]       ex_alu_in2,
   output logic [WORD_W-1:0]       ex_store,
   output logic [REG_W-1:0]        ex_rs,
   output logic [REG_W-1:0]        ex_rt,
   output logic [REG_W-1:0]        ex_wsel,
   output logic                    ex_memread,
   output logic [PAY_W-1:0]        ex_payload
);

   logic              valid_q, valid_d;
   logic [WORD_W-1:0] aluIn1_q, aluIn1_d;
   logic [WORD_W-1:0] aluIn2_q, aluIn2_d;
   logic [WORD_W-1:0] store_q, store_d;
   logic              fwd1_q, fwd1_d;
   logic              fwd2_q, fwd2_d;
   logic [REG_W-1:0]  rs_q, rs_d;
   logic [REG_W-1:0]  rt_q, rt_d;
   logic [REG_W-1:0]  wsel_q, wsel_d;
   logic              memread_q, memread_d;
   logic [PAY_W-1:0]  payload_q, payload_d;
   logic              pendFlush_q, pendFlush_d;

   // Iterating from the oldest source down lets the youngest match overwrite last.
   function automatic logic [WORD_W-1:0] forwardOp(
      input logic [WORD_W-1:0]      base,
      input logic [REG_W-1:0]       sel,
      input logic                   en,
      input logic [NFWD-1:0]        fv,
      input logic [NFWD*REG_W-1:0]  fw,
      input logic [NFWD*WORD_W-1:0] fd
   );
      logic [WORD_W-1:0] result;
      result = base;
      for (int i = NFWD - 1; i >= 0; i--) begin
         if (en && (sel != '0) && fv[i] && (fw[i*REG_W +: REG_W] == sel)) begin
            result = fd[i*WORD_W +: WORD_W];
         end
      end
      return result;
   endfunction

   assign ex_alu_in1 = forwardOp(aluIn1_q, rs_q, fwd1_q, fwd_valid, fwd_wsel, fwd_wdat);
   assign ex_alu_in2 = forwardOp(aluIn2_q, rt_q, fwd2_q, fwd_valid, fwd_wsel, fwd_wdat);
   assign ex_store   = forwardOp(store_q, rt_q, 1'b1, fwd_valid, fwd_wsel, fwd_wdat);

   assign ex_valid   = valid_q;
   assign ex_rs      = rs_q;
   assign ex_rt      = rt_q;
   assign ex_wsel    = wsel_q;
   assign ex_memread = memread_q;
   assign ex_payload = payload_q;

   // rt is checked regardless of dec_fwd2 because a store still reads it.
   assign hazard = dec_valid & valid_q & memread_q & (wsel_q != '0) &
                   ((dec_fwd1 & (dec_rs == wsel_q)) | (dec_rt == wsel_q));

   always_comb begin
      valid_d     = valid_q;
      aluIn1_d    = aluIn1_q;
      aluIn2_d    = aluIn2_q;
      store_d     = store_q;
      fwd1_d      = fwd1_q;
      fwd2_d      = fwd2_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      wsel_d      = wsel_q;
      memread_d   = memread_q;
      payload_d   = payload_q;
      pendFlush_d = pendFlush_q;
      if (stall) begin
         // Capture forwarded values so a producer retiring mid-stall is not lost.
         aluIn1_d    = ex_alu_in1;
         aluIn2_d    = ex_alu_in2;
         store_d     = ex_store;
         pendFlush_d = pendFlush_q | flush;
      end else if (flush || pendFlush_q) begin
         valid_d     = 1'b0;
         pendFlush_d = 1'b0;
      end else if (hazard) begin
         valid_d = 1'b0;
      end else begin
         valid_d   = dec_valid;
         aluIn1_d  = dec_alu_in1;
         aluIn2_d  = dec_alu_in2;
         store_d   = dec_store;
         fwd1_d    = dec_fwd1;
         fwd2_d    = dec_fwd2;
         rs_d      = dec_rs;
         rt_d      = dec_rt;
         wsel_d    = dec_wsel;
         memread_d = dec_memread;
         payload_d = dec_payload;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid_q     <= 1'b0;
         aluIn1_q    <= '0;
         aluIn2_q    <= '0;
         store_q     <= '0;
         fwd1_q      <= 1'b0;
         fwd2_q      <= 1'b0;
         rs_q        <= '0;
         rt_q        <= '0;
         wsel_q      <= '0;
         memread_q   <= 1'b0;
         payload_q   <= '0;
         pendFlush_q <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         aluIn1_q    <= aluIn1_d;
         aluIn2_q    <= aluIn2_d;
         store_q     <= store_d;
         fwd1_q      <= fwd1_d;
         fwd2_q      <= fwd2_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         wsel_q      <= wsel_d;
         memread_q   <= memread_d;
         payload_q   <= payload_d;
         pendFlush_q <= pendFlush_d;
      end
   end

endmodule
